// File: rtl/decode_queue_pkg.sv
// Shared RV32I decode types for the decode queue.
// The decoded bundle carries muldiv/muldiv_op only when DECODE_QUEUE_RV32M_EN is defined.
package cpu_types;

  typedef enum logic [1:0] {
    MASK_BYTE = 2'b00,
    MASK_HALF = 2'b01,
    MASK_WORD = 2'b10
  } memory_mask_t;

  typedef enum logic [2:0] {UNKNOWN, R, I, S, SB, U, UJ} instruction_type_t;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } muldiv_op_t;

  typedef enum logic {ST_RUN, ST_HALT} queue_state_t;

  // opcode[6:2]; opcode[1:0] must be 2'b11 for every legal word
  localparam logic [4:0] OP       = 5'b01100;
  localparam logic [4:0] OP_IMM   = 5'b00100;
  localparam logic [4:0] LOAD     = 5'b00000;
  localparam logic [4:0] STORE    = 5'b01000;
  localparam logic [4:0] BRANCH   = 5'b11000;
  localparam logic [4:0] JAL      = 5'b11011;
  localparam logic [4:0] JALR     = 5'b11001;
  localparam logic [4:0] LUI      = 5'b01101;
  localparam logic [4:0] AUIPC    = 5'b00101;
  localparam logic [4:0] SYSTEM   = 5'b11100;
  localparam logic [4:0] MISC_MEM = 5'b00011;

  typedef struct packed {
    instruction_type_t instruction_type;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       immediate;
    logic              use_immediate;
    logic              use_pc;
    logic              reg_we;
    logic              load_memory;
    logic              store_memory;
    memory_mask_t      memory_mask;
    logic              sign_extend;
    logic              jump;
    logic              jump_register;
    logic              branch;
    logic [2:0]        alu_funct3;
    logic              alu_reg_add_one;
    logic              negate;
    logic              shift_arith;
    logic              ebreak;
`ifdef DECODE_QUEUE_RV32M_EN
    logic              muldiv;
    muldiv_op_t        muldiv_op;
`endif
  } decoded_ctrl_t;

endpackage

// File: rtl/decode_queue_decode_core.sv
// Combinational RV32I decoder: instruction word -> decoded_ctrl_t plus illegal flag.
// With DECODE_QUEUE_RV32M_EN the OP/funct7=0000001 space decodes as mul/div, otherwise it is illegal.
module decode_core
  import cpu_types::*;
(
  input  logic [31:0]   instruction,
  output decoded_ctrl_t ctrl,
  output logic          illegal
);

  logic [4:0]  op5;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        md_enc;
  logic        known;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign op5    = instruction[6:2];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];
  assign md_enc = (op5 == OP) && (funct7 == 7'b0000001);

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  always_comb begin
    ctrl    = '0;
    known   = 1'b1;
    illegal = 1'b0;
    ctrl.rd  = instruction[11:7];
    ctrl.rs1 = instruction[19:15];
    ctrl.rs2 = instruction[24:20];
    case (op5)
      OP: begin
        ctrl.instruction_type = R;
        ctrl.reg_we           = 1'b1;
        ctrl.alu_funct3       = funct3;
        ctrl.alu_reg_add_one  = (funct3 == 3'b000) && funct7[5];
        ctrl.negate           = (funct3 == 3'b000) && funct7[5];
        ctrl.shift_arith      = (funct3 == 3'b101) && funct7[5];
      end
      OP_IMM: begin
        ctrl.instruction_type = I;
        ctrl.immediate        = imm_i;
        ctrl.use_immediate    = 1'b1;
        ctrl.reg_we           = 1'b1;
        ctrl.alu_funct3       = funct3;
        ctrl.shift_arith      = (funct3 == 3'b101) && funct7[5];
      end
      LOAD: begin
        ctrl.instruction_type = I;
        ctrl.immediate        = imm_i;
        ctrl.use_immediate    = 1'b1;
        ctrl.reg_we           = 1'b1;
        ctrl.load_memory      = 1'b1;
        ctrl.memory_mask      = memory_mask_t'(funct3[1:0]);
        ctrl.sign_extend      = !funct3[2];
      end
      STORE: begin
        ctrl.instruction_type = S;
        ctrl.immediate        = imm_s;
        ctrl.use_immediate    = 1'b1;
        ctrl.store_memory     = 1'b1;
        ctrl.memory_mask      = memory_mask_t'(funct3[1:0]);
      end
      BRANCH: begin
        ctrl.instruction_type = SB;
        ctrl.immediate        = imm_b;
        ctrl.branch           = 1'b1;
      end
      JAL: begin
        ctrl.instruction_type = UJ;
        ctrl.immediate        = imm_j;
        ctrl.use_immediate    = 1'b1;
        ctrl.use_pc           = 1'b1;
        ctrl.reg_we           = 1'b1;
        ctrl.jump             = 1'b1;
      end
      JALR: begin
        ctrl.instruction_type = I;
        ctrl.immediate        = imm_i;
        ctrl.use_immediate    = 1'b1;
        ctrl.reg_we           = 1'b1;
        ctrl.jump             = 1'b1;
        ctrl.jump_register    = 1'b1;
      end
      LUI: begin
        ctrl.instruction_type = U;
        ctrl.immediate        = imm_u;
        ctrl.use_immediate    = 1'b1;
        ctrl.reg_we           = 1'b1;
        ctrl.rs1              = 5'd0;
      end
      AUIPC: begin
        ctrl.instruction_type = U;
        ctrl.immediate        = imm_u;
        ctrl.use_immediate    = 1'b1;
        ctrl.use_pc           = 1'b1;
        ctrl.reg_we           = 1'b1;
      end
      SYSTEM: begin
        ctrl.instruction_type = I;
        ctrl.immediate        = imm_i;
        ctrl.ebreak           = (funct3 == 3'b000);
      end
      MISC_MEM: begin
        ctrl.instruction_type = I;
        ctrl.immediate        = imm_i;
      end
      default: known = 1'b0;
    endcase
`ifdef DECODE_QUEUE_RV32M_EN
    if (md_enc) begin
      ctrl.muldiv    = 1'b1;
      ctrl.muldiv_op = muldiv_op_t'(funct3);
    end
    illegal = !known || (instruction[1:0] != 2'b11);
`else
    illegal = !known || (instruction[1:0] != 2'b11) || md_enc;
`endif
    // an illegal word still travels down the pipe but must have no side effects
    if (illegal) begin
      ctrl.reg_we        = 1'b0;
      ctrl.load_memory   = 1'b0;
      ctrl.store_memory  = 1'b0;
      ctrl.jump          = 1'b0;
      ctrl.jump_register = 1'b0;
      ctrl.branch        = 1'b0;
      ctrl.ebreak        = 1'b0;
    end
  end

endmodule

// File: rtl/fifo.sv
// Generic DEPTH-entry valid/ready FIFO with synchronous clear; read data is registered storage.
// Write is refused when full (no pass-through); clear overrides same-cycle write and read.
module fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         wr_vld,
  output logic         wr_rdy,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_fire;
  logic             rd_fire;

  assign wr_rdy  = (count != CNT_W'(DEPTH));
  assign rd_vld  = (count != '0);
  assign rd_dat  = mem[rd_ptr];
  assign wr_fire = wr_vld && wr_rdy;
  assign rd_fire = rd_vld && rd_rdy;

  // DEPTH is a power of two, so plain pointer overflow gives the modulo wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (wr_fire && !rd_fire) begin
        count <= count + CNT_W'(1);
      end else if (rd_fire && !wr_fire) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/decode_queue.sv
// RV32I decode stage: words decoded on entry, buffered in a DEPTH FIFO, 1-cycle latency, in_ready ignores out_ready.
// An accepted ebreak halts intake until flush; DECODE_QUEUE_RV32M_EN enables mul/div decode.
module decode_queue
  import cpu_types::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instruction,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output decoded_ctrl_t   out_ctrl,
  output logic            out_illegal,
  output logic            halted
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    decoded_ctrl_t   ctrl;
    logic            illegal;
  } entry_t;

  queue_state_t  state;
  queue_state_t  state_nxt;
  decoded_ctrl_t dec_ctrl;
  logic          dec_illegal;
  entry_t        wr_entry;
  entry_t        rd_entry;
  logic          fifo_wr_rdy;
  logic          push_vld;

  decode_core u_decode_core (
    .instruction (in_instruction),
    .ctrl        (dec_ctrl),
    .illegal     (dec_illegal)
  );

  assign wr_entry = '{pc: in_pc, ctrl: dec_ctrl, illegal: dec_illegal};
  assign in_ready = fifo_wr_rdy && (state == ST_RUN);
  assign push_vld = in_valid && in_ready;

  fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (flush),
    .wr_vld (push_vld),
    .wr_rdy (fifo_wr_rdy),
    .wr_dat (wr_entry),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (rd_entry)
  );

  assign out_pc      = rd_entry.pc;
  assign out_ctrl    = rd_entry.ctrl;
  assign out_illegal = rd_entry.illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    halted    = (state == ST_HALT);
    case (state)
      ST_RUN:  if (push_vld && dec_ctrl.ebreak) state_nxt = ST_HALT;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RUN;
    endcase
    if (flush) begin
      state_nxt = ST_RUN;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: expectations queued on each accepted push, compared on each pop.
module tb_decode_queue;
  import cpu_types::*;

  localparam int DEPTH = 2;
  localparam int PC_W  = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instruction = '0;
  logic [PC_W-1:0] in_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [PC_W-1:0] out_pc;
  decoded_ctrl_t   out_ctrl;
  logic            out_illegal;
  logic            halted;

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instruction (in_instruction),
    .in_pc          (in_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_ctrl       (out_ctrl),
    .out_illegal    (out_illegal),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        illegal;
    logic        reg_we;
    logic        store;
    logic        ebreak;
    logic        add_one;
    logic        negate;
    logic        muldiv;
    logic        chk_regs;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic        chk_imm;
    logic [31:0] imm;
  } exp_t;

  exp_t sbq[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic exp_t base(input logic [31:0] pc);
    exp_t e;
    e = '{pc: pc, illegal: 1'b0, reg_we: 1'b0, store: 1'b0, ebreak: 1'b0, add_one: 1'b0,
          negate: 1'b0, muldiv: 1'b0, chk_regs: 1'b0, rd: 5'd0, rs1: 5'd0, chk_imm: 1'b0,
          imm: 32'd0};
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !flush && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_pop", 64'(sbq.size() != 0), 1);
      end else begin
        e = sbq.pop_front();
        check("pc", out_pc, e.pc);
        check("illegal", out_illegal, e.illegal);
        check("reg_we", out_ctrl.reg_we, e.reg_we);
        check("store", out_ctrl.store_memory, e.store);
        check("ebreak", out_ctrl.ebreak, e.ebreak);
        check("add_one", out_ctrl.alu_reg_add_one, e.add_one);
        check("negate", out_ctrl.negate, e.negate);
        if (e.chk_regs) begin
          check("rd", out_ctrl.rd, e.rd);
          check("rs1", out_ctrl.rs1, e.rs1);
        end
        if (e.chk_imm) begin
          check("use_imm", out_ctrl.use_immediate, 1);
          check("imm", out_ctrl.immediate, e.imm);
        end
`ifdef DECODE_QUEUE_RV32M_EN
        check("muldiv", out_ctrl.muldiv, e.muldiv);
        if (e.muldiv) check("muldiv_op", out_ctrl.muldiv_op, MD_MUL);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
    in_valid       = 1'b1;
    in_instruction = ins;
    in_pc          = pc;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back(e);
        step();
        in_valid = 1'b0;
        return;
      end
      step();
    end
    check("send_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && sbq.size() != 0; n++) step();
    check("drain", sbq.size(), 0);
  endtask

  exp_t e_addi, e_sub, e_ebrk, e_ill, e_mul, e_sw, e_lui, e_neg;

  initial begin
    e_addi = base(32'h100);
    e_addi.reg_we = 1; e_addi.chk_regs = 1; e_addi.rd = 1; e_addi.rs1 = 0;
    e_addi.chk_imm = 1; e_addi.imm = 32'd5;
    e_sub = base(32'h108);
    e_sub.reg_we = 1; e_sub.add_one = 1; e_sub.negate = 1;
    e_sub.chk_regs = 1; e_sub.rd = 2; e_sub.rs1 = 1;
    e_ebrk = base(32'h200);
    e_ebrk.ebreak = 1;
    e_ill = base(32'h300);
    e_ill.illegal = 1;
    e_mul = base(32'h304);
`ifdef DECODE_QUEUE_RV32M_EN
    e_mul.reg_we = 1; e_mul.muldiv = 1; e_mul.chk_regs = 1; e_mul.rd = 2; e_mul.rs1 = 1;
`else
    e_mul.illegal = 1;
`endif
    e_sw = base(32'h308);
    e_sw.store = 1; e_sw.chk_imm = 1; e_sw.imm = 32'd8;
    e_lui = base(32'h30C);
    e_lui.reg_we = 1; e_lui.chk_regs = 1; e_lui.rd = 5; e_lui.rs1 = 0;
    e_lui.chk_imm = 1; e_lui.imm = 32'h1234_5000;
    e_neg = base(32'h310);
    e_neg.reg_we = 1; e_neg.chk_regs = 1; e_neg.rd = 3; e_neg.rs1 = 1;
    e_neg.chk_imm = 1; e_neg.imm = 32'hFFFF_FFFF;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_illegal", out_illegal, 0);
    check("rst_out_ctrl", 64'(|out_ctrl), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // single addi, one-cycle latency
    out_ready = 1'b1;
    send(32'h0050_0093, 32'h100, e_addi);
    @(negedge clk);
    check("lat_first", out_valid, 1);
    step();
    drain();

    // fill with stalled consumer, then drain in order
    out_ready = 1'b0;
    e_addi.pc = 32'h104;
    send(32'h0050_0093, 32'h104, e_addi);
    send(32'h4020_8133, 32'h108, e_sub);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    step();
    out_ready = 1'b1;
    drain();
    @(negedge clk);
    check("drained_in_ready", in_ready, 1);
    step();

    // ebreak halts intake while the queue drains
    out_ready = 1'b0;
    send(32'h0010_0073, 32'h200, e_ebrk);
    in_valid = 1'b1; in_instruction = 32'h0050_0093; in_pc = 32'h204;
    repeat (3) step();
    @(negedge clk);
    check("halt_halted", halted, 1);
    check("halt_in_ready", in_ready, 0);
    step();
    out_ready = 1'b1;
    drain();
    repeat (2) step();
    @(negedge clk);
    check("halt_holds", halted, 1);
    check("halt_empty", out_valid, 0);
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("unhalt_halted", halted, 0);
    check("unhalt_in_ready", in_ready, 1);
    check("unhalt_out_valid", out_valid, 0);
    step();

    // illegal word, mul/div, and assorted formats
    send(32'hFFFF_FFFF, 32'h300, e_ill);
    send(32'h0220_8133, 32'h304, e_mul);
    send(32'h0020_A423, 32'h308, e_sw);
    send(32'h1234_52B7, 32'h30C, e_lui);
    send(32'hFFF0_8193, 32'h310, e_neg);
    drain();
    @(negedge clk);
    check("illegal_no_halt", halted, 0);
    step();

    // flush with concurrent push and pop
    out_ready = 1'b0;
    e_addi.pc = 32'h400;
    send(32'h0050_0093, 32'h400, e_addi);
    e_sub.pc = 32'h404;
    send(32'h4020_8133, 32'h404, e_sub);
    flush = 1'b1; in_valid = 1'b1; in_instruction = 32'h1234_52B7; in_pc = 32'h408;
    out_ready = 1'b1;
    sbq.delete();
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    step();
    e_addi.pc = 32'h410;
    send(32'h0050_0093, 32'h410, e_addi);
    @(negedge clk);
    check("lat_after_flush", out_valid, 1);
    step();
    drain();
    out_ready = 1'b0;
    e_addi.pc = 32'h414;
    send(32'h0050_0093, 32'h414, e_addi);
    e_addi.pc = 32'h418;
    send(32'h0050_0093, 32'h418, e_addi);
    @(negedge clk);
    check("refill_in_ready", in_ready, 0);
    step();
    out_ready = 1'b1;
    drain();

    // asynchronous reset mid-operation
    out_ready = 1'b0;
    e_addi.pc = 32'h500;
    send(32'h0050_0093, 32'h500, e_addi);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_pc", out_pc, 0);
    check("arst_in_ready", in_ready, 1);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    repeat (3) step();
    check("sb_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered, parametrised RV32I decode stage between fetch and execute.
- Each accepted instruction word and its PC are decoded into one packed control bundle and buffered in a DEPTH-entry FIFO.
- Upstream and downstream each use a valid/ready handshake.
- Adds stall absorption, flush, illegal-instruction flagging and an ebreak halt state, none of which the single-cycle combinational decoder has.

Parameters:
- DEPTH, 2, FIFO entries; power of two, ≥2.
- PC_W, 32, PC width in bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all buffered entries and leave HALT
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  queue can accept this cycle
- in_instruction  in  32  raw instruction word
- in_pc  in  PC_W  PC of in_instruction
- out_valid  out  1  head entry valid
- out_ready  in  1  execute consumes head this cycle
- out_pc  out  PC_W  PC of head entry
- out_ctrl  out  $bits(decoded_ctrl_t)  decoded bundle of head entry
- out_illegal  out  1  head entry has an unknown opcode
- halted  out  1  block is in HALT state

Behaviour:
- Clock and reset: single clock; reset is asynchronous and active-low.
- Reset values: pointers=0, count=0, state=RUN, out_valid=0, halted=0, in_ready=1; out_ctrl/out_pc/out_illegal=0.
- Push: in_valid && in_ready at a rising edge. The word is decoded combinationally and {pc, ctrl, illegal} is written at wr_ptr; wr_ptr++ mod DEPTH.
- Pop: out_valid && out_ready; rd_ptr++ mod DEPTH.
- Outputs are driven from FIFO storage at rd_ptr, with no combinational path from in_*.
- Latency: a word pushed at edge N gives out_valid=1 after edge N.
- in_ready = (count < DEPTH) && state==RUN. It does not depend on out_ready, so there is no push-on-full pass-through.
- Simultaneous push and pop (count not full): count unchanged, both pointers advance.
- Empty: out_valid=0 and out_ctrl holds stale storage. The bench checks out_* only while out_valid=1.
- Pointer wrap-around: modulo DEPTH.
- State machine RUN/HALT:
  - RUN→HALT on the push of an entry with ctrl.ebreak=1 (opcode 1110011, funct3=000). The ebreak entry is stored and delivered normally.
  - In HALT, in_ready=0 and halted=1; buffered entries continue to drain.
  - HALT→RUN only on flush.
- flush (highest priority, synchronous):
  - next state: count=0, pointers=0, state=RUN.
  - A same-cycle push or pop is ignored and in_valid is dropped.
  - out_valid=0 the cycle after.
- Decode rules:
  - instruction_type, immediate formats, rs1/rs2/rd, reg_we, load/store, memory_mask, sign extension, jump and ALU fields follow the existing decode conventions in cpu_types.
  - LUI forces rs1=0.
  - Subtraction: R-type, funct3=0, funct7[5]=1 sets add_one and negate.
- Illegal opcode: opcode[6:2] outside the supported set, or opcode[1:0]≠11.
  - illegal=1 and reg_we, store_memory, jumps and ebreak are forced to 0; the entry is still queued.
- Asynchronous reset mid-operation: all entries are lost and outputs return to reset values immediately.

Optional Feature:
- Macro: DECODE_QUEUE_RV32M_EN.
- Defined: opcode 0110011 with funct7=0000001 decodes as multiply/divide.
  - ctrl.muldiv=1 and ctrl.muldiv_op=funct3 (mul..remu); reg_we=1 and ALU fields are don't-care.
- Undefined: the same encoding sets illegal=1. The muldiv fields are absent from decoded_ctrl_t and muldiv is never set.

Decomposition:
- cpu_types package (existing): add
  - decoded_ctrl_t (packed struct with all decode outputs, plus muldiv/muldiv_op under the macro);
  - instruction_type_t enum {UNKNOWN,R,I,S,SB,U,UJ};
  - opcode5 constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MISC_MEM);
  - muldiv_op_t.
- Reuse the existing memory_mask_t.
- Sub-module decode_core: purely combinational, instruction → {decoded_ctrl_t, illegal}. decode_queue instantiates it on the input side.

Test Plan:
- addi x1,x0,5 (0x00500093, pc=0x100), out_ready=1 → the next cycle out_valid=1, rd=1, rs1=0, immediate=5, use_immediate=1, reg_we=1, out_pc=0x100, illegal=0.
- DEPTH=2, out_ready=0, push 0x00500093 then 0x40208133 (sub) → in_ready=0 after the second push. Then raise out_ready → the entries pop in order; the sub entry has alu_reg_add_one=1 and negate=1; in_ready returns to 1.
- Push ebreak 0x00100073 followed by in_valid held high → halted=1, in_ready=0; ebreak delivered with ctrl.ebreak=1. A flush pulse → halted=0, in_ready=1, queue empty.
- Push 0xFFFFFFFF → out_illegal=1, reg_we=0, store_memory=0, no HALT.
- mul x2,x1,x2 (0x02208133) → with the macro: muldiv=1, muldiv_op=000, illegal=0. Without the macro: illegal=1.
- Two entries queued, then flush asserted together with in_valid and out_ready → the next cycle out_valid=0 and count=0; the in-flight word is dropped, and the next push returns to the 1-cycle latency.
